// File: rtl/uint16_to_half_converter_if.sv
// Request/result bundle between the operand source and the
// uint16 -> binary16 converter.
interface uint16_to_half_converter_if;
  logic [15:0] dataIn;
  logic        R_I;
  logic [15:0] dataOut;
  logic        R_O;
  logic        REG_ERROR;

  modport master (
    output dataIn,
    output R_I,
    input  dataOut,
    input  R_O,
    input  REG_ERROR
  );

  modport slave (
    input  dataIn,
    input  R_I,
    output dataOut,
    output R_O,
    output REG_ERROR
  );
endinterface

// File: rtl/uint16_to_half_converter.sv
// Multi-cycle uint16 -> IEEE binary16 converter, round to
// nearest even, saturating to +Inf with an error pulse.
module uint16_to_half_converter (
  input logic                          clk,
  input logic                          reset,
  uint16_to_half_converter_if.slave    io
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] w;
  logic [3:0]  lz;

  logic [9:0]  mant;
  logic        guard;
  logic        sticky;
  logic        rnd;
  logic [10:0] mant_rnd;
  logic [4:0]  exp_base;
  logic [4:0]  exp_rnd;
  logic        ovf;
  logic [15:0] half;

  // w is left-aligned here, so bit 15 is the hidden one
  always_comb begin
    mant     = w[14:5];
    guard    = w[4];
    sticky   = |w[3:0];
    rnd      = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {10'd0, rnd};
    exp_base = 5'd30 - {1'b0, lz};
    exp_rnd  = exp_base + {4'd0, mant_rnd[10]};
    ovf      = (exp_rnd == 5'd31);
    half     = ovf ? 16'h7C00
                   : {1'b0, exp_rnd, mant_rnd[9:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // a zero operand has no leading one to find, so it
  // bypasses NORM and gets its zero result in ROUND
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (io.R_I) begin
          state_nxt = (io.dataIn == 16'd0) ? ROUND : NORM;
        end
      end
      NORM: begin
        if (w[15]) begin
          state_nxt = ROUND;
        end
      end
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w            <= 16'd0;
      lz           <= 4'd0;
      io.dataOut   <= 16'd0;
      io.R_O       <= 1'b0;
      io.REG_ERROR <= 1'b0;
    end else begin
      io.R_O       <= 1'b0;
      io.REG_ERROR <= 1'b0;
      case (state)
        IDLE: begin
          if (io.R_I) begin
            w  <= io.dataIn;
            lz <= 4'd0;
          end
        end
        NORM: begin
          if (!w[15]) begin
            w  <= {w[14:0], 1'b0};
            lz <= lz + 4'd1;
          end
        end
        ROUND: begin
          io.R_O       <= 1'b1;
          io.REG_ERROR <= (w != 16'd0) & ovf;
          io.dataOut   <= (w == 16'd0) ? 16'd0 : half;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uint16_to_half_converter.sv
// Directed bench for uint16_to_half_converter: latency,
// rounding, overflow, ignored requests and reset abort.
module tb_uint16_to_half_converter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  uint16_to_half_converter_if io ();

  uint16_to_half_converter dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic convert(input string tag,
                         input logic [15:0] v,
                         input int lat,
                         input logic [15:0] exp,
                         input logic err);
    int n;
    bit seen;
    @(negedge clk);
    io.dataIn = v;
    io.R_I    = 1'b1;
    @(posedge clk);
    #1;
    io.R_I = 1'b0;
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < 40) begin
      if (io.R_O) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_out"}, 32'(io.dataOut), 32'(exp));
    chk({tag, "_err"}, 32'(io.REG_ERROR), 32'(err));
    @(posedge clk);
    #1;
    chk({tag, "_ro_drop"}, 32'(io.R_O), 32'd0);
    chk({tag, "_err_drop"}, 32'(io.REG_ERROR), 32'd0);
    chk({tag, "_hold"}, 32'(io.dataOut), 32'(exp));
  endtask

  initial begin
    int pulses;
    int first;
    logic [15:0] captured;
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    io.R_I    = 1'b0;
    io.dataIn = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(io.dataOut), 32'h0000);
    chk("rst_ro", 32'(io.R_O), 32'd0);
    chk("rst_err", 32'(io.REG_ERROR), 32'd0);

    convert("zero", 16'h0000, 1, 16'h0000, 1'b0);
    convert("one", 16'h0001, 17, 16'h3C00, 1'b0);
    convert("msb", 16'h8000, 2, 16'h7800, 1'b0);
    convert("tie_even", 16'h0801, 6, 16'h6800, 1'b0);
    convert("tie_up", 16'h0803, 6, 16'h6802, 1'b0);
    convert("max_fin", 16'hFFEF, 2, 16'h7BFF, 1'b0);
    convert("ovf_tie", 16'hFFF0, 2, 16'h7C00, 1'b1);
    convert("ovf_max", 16'hFFFF, 2, 16'h7C00, 1'b1);
    convert("three", 16'h0003, 16, 16'h4200, 1'b0);

    // extra requests in NORM and in DONE must be dropped
    @(negedge clk);
    io.dataIn = 16'h0001;
    io.R_I    = 1'b1;
    @(posedge clk);
    #1;
    io.R_I   = 1'b0;
    pulses   = 0;
    first    = -1;
    captured = 16'd0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (io.R_O) begin
        pulses++;
        if (first < 0) begin
          first    = k;
          captured = io.dataOut;
        end
        io.R_I    = 1'b1;
        io.dataIn = 16'h8000;
      end else begin
        io.R_I    = (k == 3);
        io.dataIn = 16'h8000;
      end
    end
    io.R_I = 1'b0;
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_lat", 32'(first), 32'd17);
    chk("ign_out", 32'(captured), 32'h3C00);

    // reset five cycles into NORM aborts the conversion
    @(negedge clk);
    io.dataIn = 16'h0001;
    io.R_I    = 1'b1;
    @(negedge clk);
    io.R_I = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (io.R_O) pulses++;
    end
    chk("abort_pulses", 32'(pulses), 32'd0);
    chk("abort_out", 32'(io.dataOut), 32'h0000);
    chk("abort_err", 32'(io.REG_ERROR), 32'd0);
    convert("after_abort", 16'h0001, 17, 16'h3C00, 1'b0);

    // reset and request on the same edge: request dropped
    @(negedge clk);
    reset     = 1'b1;
    io.R_I    = 1'b1;
    io.dataIn = 16'h8000;
    @(negedge clk);
    reset  = 1'b0;
    io.R_I = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (io.R_O) pulses++;
    end
    chk("rst_req_pulses", 32'(pulses), 32'd0);
    chk("rst_req_out", 32'(io.dataOut), 32'h0000);
    convert("final", 16'h1000, 5, 16'h6C00, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
